gmii_tx_sched: RTL and testbench

GMII_TX_SCHED -- requirements
Module: gmii_tx_sched

---
 rtl/gmii_tx_pkg.sv | 25 ++
 rtl/gmii_tx_wdog.sv | 29 ++
 rtl/gmii_tx_sched.sv | 121 ++++++++++++
 tb/tb_gmii_tx_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_pkg.sv
// GMII transmit scheduler shared definitions.
// Packet type codes, FSM encodings and the audio count clamp.
package gmii_tx_pkg;

    localparam logic [1:0] PKT_VIDEO = 2'd0;
    localparam logic [1:0] PKT_AUDIO = 2'd1;
    localparam logic [1:0] PKT_VIDAX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // An audio grant always carries at least one entry.
    function automatic logic [4:0] aud_clamp(
        input logic [4:0] num,
        input logic [4:0] lim
    );
        if (num == 5'd0) return 5'd1;
        if (num > lim) return lim;
        return num;
    endfunction

endpackage

// File: rtl/gmii_tx_wdog.sv
// Busy-cycle watchdog for the GMII transmit scheduler.
// Counts while run is high; expire fires on the last allowed cycle.
module gmii_tx_wdog #(
    parameter int WDOG_MAX = 4095
) (
    input  logic tx_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(WDOG_MAX - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge tx_clk) begin
        if (sys_rst || !run) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A tx_done on the final cycle still counts as a clean finish.
    assign expire = run && !kick && (cnt == LAST);

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII packet scheduler: arbitrates video/audio, tracks the packet in flight.
// Define GMII_TX_SCHED_VIDAX_EN to piggyback one audio entry on video.
module gmii_tx_sched
    import gmii_tx_pkg::*;
#(
    parameter int AUD_MAX     = 20,
    parameter int AUD_TIMEOUT = 255,
    parameter int VID_BURST   = 4,
    parameter int WDOG_MAX    = 4095
) (
    input  logic       tx_clk,
    input  logic       sys_rst,
    input  logic       vid_req,
    input  logic       aud_req,
    input  logic [4:0] aud_num,
    input  logic       tx_done,
    output logic       start,
    output logic [1:0] pkt_type,
    output logic [4:0] aud_cnt,
    output logic       busy,
    output logic       wdog_err
);

    localparam int AW = $clog2(AUD_TIMEOUT + 1);
    localparam int SW = $clog2(VID_BURST + 1);
    localparam logic [4:0]    AUD_LIM = 5'(AUD_MAX);
    localparam logic [AW-1:0] AGE_SAT = AW'(AUD_TIMEOUT);
    localparam logic [SW-1:0] VID_SAT = SW'(VID_BURST);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] aud_age;
    logic [SW-1:0] vid_streak;
    logic          urgent;
    logic          grant;
    logic          aud_clr;
    logic          wdog_exp;
    logic [1:0]    g_type;
    logic [4:0]    g_cnt;

    assign urgent = aud_req && ((aud_age >= AGE_SAT) ||
                                (aud_num >= AUD_LIM) ||
                                (vid_streak >= VID_SAT));

    always_comb begin
        g_type = PKT_VIDEO;
        g_cnt  = 5'd0;
        if (urgent) begin
            g_type = PKT_AUDIO;
            g_cnt  = aud_clamp(aud_num, AUD_LIM);
        end else if (vid_req) begin
`ifdef GMII_TX_SCHED_VIDAX_EN
            if (aud_req) begin
                g_type = PKT_VIDAX;
                g_cnt  = 5'd1;
            end
`else
            g_type = PKT_VIDEO;
            g_cnt  = 5'd0;
`endif
        end else if (aud_req) begin
            g_type = PKT_AUDIO;
            g_cnt  = aud_clamp(aud_num, AUD_LIM);
        end
    end

    assign grant   = (state == ST_IDLE) && (vid_req || aud_req);
    assign aud_clr = grant && (g_type != PKT_VIDEO);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (vid_req || aud_req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_BUSY;
            ST_BUSY:  if (tx_done || wdog_exp) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            pkt_type   <= PKT_VIDEO;
            aud_cnt    <= 5'd0;
            aud_age    <= '0;
            vid_streak <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                pkt_type <= g_type;
                aud_cnt  <= g_cnt;
            end
            if (aud_clr || !aud_req) begin
                aud_age <= '0;
            end else if (aud_age != AGE_SAT) begin
                aud_age <= aud_age + 1'b1;
            end
            // Only video grants survive aud_clr, so this counts video-only grants.
            if (aud_clr) begin
                vid_streak <= '0;
            end else if (grant && aud_req && (vid_streak != VID_SAT)) begin
                vid_streak <= vid_streak + 1'b1;
            end
        end
    end

    gmii_tx_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .tx_clk  (tx_clk),
        .sys_rst (sys_rst),
        .run     (state == ST_BUSY),
        .kick    (tx_done),
        .expire  (wdog_exp)
    );

    assign start    = (state == ST_GRANT);
    assign busy     = (state != ST_IDLE);
    assign wdog_err = wdog_exp;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed plus randomized bench for gmii_tx_sched.
// Expectations come from a packet-level model of the arbitration rules.
module tb_gmii_tx_sched;

    logic       tx_clk;
    logic       sys_rst;
    logic       vid_req;
    logic       aud_req;
    logic [4:0] aud_num;
    logic       tx_done;
    logic       start;
    logic [1:0] pkt_type;
    logic [4:0] aud_cnt;
    logic       busy;
    logic       wdog_err;

    int total = 0;
    int bad   = 0;
    int m_age    = 0;
    int m_streak = 0;

    gmii_tx_sched dut (
        .tx_clk   (tx_clk),
        .sys_rst  (sys_rst),
        .vid_req  (vid_req),
        .aud_req  (aud_req),
        .aud_num  (aud_num),
        .tx_done  (tx_done),
        .start    (start),
        .pkt_type (pkt_type),
        .aud_cnt  (aud_cnt),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int aud_entries(input int num);
        if (num == 0) return 1;
        if (num > 20) return 20;
        return num;
    endfunction

    // Grant decision from the priority rules and the model's age/streak.
    task automatic predict(input bit v, input bit a, input int num,
                           output int typ, output int cnt);
        bit urg;
        urg = a && (m_age >= 255 || num >= 20 || m_streak >= 4);
        if (urg || (!v && a)) begin
            typ = 1;
            cnt = aud_entries(num);
        end else begin
            typ = 0;
            cnt = 0;
`ifdef GMII_TX_SCHED_VIDAX_EN
            if (a) begin
                typ = 2;
                cnt = 1;
            end
`endif
        end
    endtask

    task automatic clk1(input bit clr);
        @(posedge tx_clk);
        #1;
        if (sys_rst || clr || !aud_req) m_age = 0;
        else if (m_age < 255) m_age++;
        if (sys_rst) m_streak = 0;
    endtask

    task automatic grant_chk(input bit v, input bit a, input int num,
                             input bit spur);
        int typ;
        int cnt;
        vid_req = v;
        aud_req = a;
        aud_num = 5'(num);
        tx_done = spur;
        predict(v, a, num, typ, cnt);
        clk1(typ != 0);
        if (typ != 0) m_streak = 0;
        else if (a && m_streak < 4) m_streak++;
        chk("grant_start", {31'd0, start}, 1);
        chk("grant_busy", {31'd0, busy}, 1);
        chk("pkt_type", {30'd0, pkt_type}, 32'(typ));
        chk("aud_cnt", {27'd0, aud_cnt}, 32'(cnt));
    endtask

    task automatic drain(input int blen);
        clk1(1'b0);
        tx_done = 1'b0;
        chk("busy_start", {31'd0, start}, 0);
        chk("busy_busy", {31'd0, busy}, 1);
        repeat (blen - 1) clk1(1'b0);
        tx_done = 1'b1;
        clk1(1'b0);
        tx_done = 1'b0;
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_start", {31'd0, start}, 0);
        chk("idle_wdog", {31'd0, wdog_err}, 0);
    endtask

    task automatic packet(input bit v, input bit a, input int num,
                          input int blen, input bit spur);
        grant_chk(v, a, num, spur);
        drain(blen);
    endtask

    initial begin
        int n;
        sys_rst = 1'b1;
        vid_req = 1'b0;
        aud_req = 1'b0;
        aud_num = 5'd0;
        tx_done = 1'b0;
        clk1(1'b0);
        clk1(1'b0);
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_type", {30'd0, pkt_type}, 0);
        chk("rst_cnt", {27'd0, aud_cnt}, 0);
        chk("rst_wdog", {31'd0, wdog_err}, 0);
        sys_rst = 1'b0;
        tx_done = 1'b1;
        clk1(1'b0);
        tx_done = 1'b0;
        chk("idle_no_req", {31'd0, busy}, 0);

        // video only, fastest turnaround
        for (int i = 0; i < 3; i++) packet(1'b1, 1'b0, 0, 1, 1'b0);
        // audio capped at AUD_MAX
        packet(1'b0, 1'b1, 25, 2, 1'b0);
        // empty audio FIFO count still sends one entry
        packet(1'b0, 1'b1, 0, 1, 1'b1);
        // video burst then forced audio, then streak restarts
        for (int i = 0; i < 6; i++) packet(1'b1, 1'b1, 2, 1, 1'b0);
        // long packet lets audio age saturate
        packet(1'b1, 1'b1, 1, 300, 1'b0);
        packet(1'b1, 1'b1, 1, 1, 1'b0);
        packet(1'b1, 1'b1, 1, 1, 1'b0);

        // watchdog abort
        grant_chk(1'b1, 1'b0, 0, 1'b0);
        tx_done = 1'b0;
        n = 0;
        while (n < 5000) begin
            clk1(1'b0);
            n++;
            if (wdog_err === 1'b1) break;
        end
        chk("wdog_cycles", 32'(n), 4095);
        clk1(1'b0);
        chk("wdog_idle", {31'd0, busy}, 0);
        chk("wdog_pulse", {31'd0, wdog_err}, 0);
        packet(1'b1, 1'b0, 0, 1, 1'b0);

        // reset in the middle of a packet
        grant_chk(1'b1, 1'b1, 3, 1'b0);
        clk1(1'b0);
        clk1(1'b0);
        sys_rst = 1'b1;
        vid_req = 1'b0;
        aud_req = 1'b0;
        clk1(1'b0);
        chk("mid_rst_start", {31'd0, start}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_type", {30'd0, pkt_type}, 0);
        chk("mid_rst_cnt", {27'd0, aud_cnt}, 0);
        chk("mid_rst_wdog", {31'd0, wdog_err}, 0);
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1(1'b0);
            chk("post_rst_start", {31'd0, start}, 0);
            chk("post_rst_busy", {31'd0, busy}, 0);
        end

        // random traffic
        for (int i = 0; i < 60; i++) begin
            bit v;
            bit a;
            int gap;
            v = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            if (!v && !a) v = 1'b1;
            packet(v, a, int'($urandom_range(0, 31)),
                   int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            gap = int'($urandom_range(0, 2));
            vid_req = 1'b0;
            aud_req = 1'b0;
            for (int g = 0; g < gap; g++) begin
                clk1(1'b0);
                chk("gap_start", {31'd0, start}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
